// File: rtl/chess_button_frontend.sv
// chess_button_frontend: player-side button front end for chess_clock.
// Synchronises and debounces the raw buttons, then turns them into game control.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   btn_start          raw start button (asynchronous)
//   btn_p1, btn_p2     raw player paddles (asynchronous)
//   timeout_p1/p2      time-expired flags fed back from chess_clock
//   start              level, high while a game is running
//   switch_turn        one-cycle pulse per accepted turn hand-over
//   surrender_player1  player 1 resigned, held while the game is over
//   surrender_player2  player 2 resigned, held while the game is over
//   active_player      0 = player 1 to move, 1 = player 2
//   game_over          high while the game is over
module chess_button_frontend #(
    parameter int DEBOUNCE_CYCLES       = 4,
    parameter int SURRENDER_HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_p1,
    input  logic btn_p2,
    input  logic timeout_p1,
    input  logic timeout_p2,
    output logic start,
    output logic switch_turn,
    output logic surrender_player1,
    output logic surrender_player2,
    output logic active_player,
    output logic game_over
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(SURRENDER_HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX  = HW'(SURRENDER_HOLD_CYCLES);
    localparam logic [HW-1:0] HLAST = HW'(SURRENDER_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    // Bit 0 = start, bit 1 = player 1 paddle, bit 2 = player 2 paddle.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [DW-1:0] dcnt [3];

    // Index 0 = player 1 paddle, index 1 = player 2 paddle.
    logic [HW-1:0] hold [2];
    logic [1:0]    long_fire;

    logic       start_rise;
    logic [1:0] short_rel;

    state_t state;
    state_t state_next;
    logic   switch_next;
    logic   sur1_next;
    logic   sur2_next;
    logic   active_next;

    assign raw = {btn_p2, btn_p1, btn_start};

    // Synchroniser and debounce: the level flips once the synchronised
    // sample has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DLAST) begin
                        deb[i]  <= ~deb[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Hold counters saturate, so long_fire can only pulse once per press:
    // it marks the cycle in which the count first sits at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold[0]   <= '0;
            hold[1]   <= '0;
            long_fire <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (deb[p+1]) begin
                    if (hold[p] != HMAX) begin
                        hold[p] <= hold[p] + HW'(1);
                    end
                end else begin
                    hold[p] <= '0;
                end
                long_fire[p] <= deb[p+1] && (hold[p] == HLAST);
            end
        end
    end

    assign start_rise = deb[0] & ~deb_q[0];

    // The hold count still shows the length of the press on the falling
    // cycle, so a press that reached the limit never counts as a tap.
    assign short_rel[0] = ~deb[1] & deb_q[1] & (hold[0] < HMAX);
    assign short_rel[1] = ~deb[2] & deb_q[2] & (hold[1] < HMAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            start             <= 1'b0;
            switch_turn       <= 1'b0;
            surrender_player1 <= 1'b0;
            surrender_player2 <= 1'b0;
            active_player     <= 1'b0;
            game_over         <= 1'b0;
        end else begin
            state             <= state_next;
            start             <= (state_next == RUN);
            switch_turn       <= switch_next;
            surrender_player1 <= sur1_next;
            surrender_player2 <= sur2_next;
            active_player     <= active_next;
            game_over         <= (state_next == OVER);
        end
    end

    always_comb begin
        state_next  = state;
        switch_next = 1'b0;
        sur1_next   = surrender_player1;
        sur2_next   = surrender_player2;
        active_next = active_player;
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next  = RUN;
                    active_next = 1'b0;
                end
            end
            RUN: begin
                if (timeout_p1 || timeout_p2) begin
                    state_next = OVER;
                end else if (|long_fire) begin
                    state_next = OVER;
                    sur1_next  = long_fire[0];
                    sur2_next  = long_fire[1];
                end else if (short_rel[active_player]) begin
                    switch_next = 1'b1;
                    active_next = ~active_player;
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_next  = IDLE;
                    sur1_next   = 1'b0;
                    sur2_next   = 1'b0;
                    active_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                sur1_next   = 1'b0;
                sur2_next   = 1'b0;
                active_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_chess_button_frontend.sv
// tb_chess_button_frontend: directed and random stimulus for
// chess_button_frontend, checked every cycle against a behavioural model.
module tb_chess_button_frontend;

    localparam int D = 4;
    localparam int H = 20;

    logic clk = 1'b0;
    logic reset;
    logic btn_start;
    logic btn_p1;
    logic btn_p2;
    logic timeout_p1;
    logic timeout_p2;
    logic start;
    logic switch_turn;
    logic surrender_player1;
    logic surrender_player2;
    logic active_player;
    logic game_over;

    int checks = 0;
    int errors = 0;

    chess_button_frontend #(
        .DEBOUNCE_CYCLES(D),
        .SURRENDER_HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_p1(btn_p1),
        .btn_p2(btn_p2),
        .timeout_p1(timeout_p1),
        .timeout_p2(timeout_p2),
        .start(start),
        .switch_turn(switch_turn),
        .surrender_player1(surrender_player1),
        .surrender_player2(surrender_player2),
        .active_player(active_player),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Behavioural model. hist[b][0] is the newest raw sample; the debounced
    // level flips once the D samples seen after the 2-cycle synchroniser
    // delay all disagree with it. run[p] is the unsaturated length of the
    // current debounced press (capped just above H).
    bit hist [3][0:D];
    bit m_deb [3];
    bit m_debp [3];
    int m_run [2];
    int m_phase;
    bit m_start, m_sw, m_s1, m_s2, m_act, m_go;

    task automatic model_step();
        bit r [3];
        bit rise;
        bit lng [2];
        bit shr [2];
        bit flip;
        r[0] = btn_start;
        r[1] = btn_p1;
        r[2] = btn_p2;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_deb[b]  = 0;
                m_debp[b] = 0;
                for (int j = 0; j <= D; j++) hist[b][j] = 0;
            end
            m_run[0] = 0;
            m_run[1] = 0;
            m_phase  = 0;
            m_sw     = 0;
            m_s1     = 0;
            m_s2     = 0;
            m_act    = 0;
        end else begin
            rise = m_deb[0] && !m_debp[0];
            for (int p = 0; p < 2; p++) begin
                lng[p] = (m_run[p] == H);
                shr[p] = !m_deb[p+1] && m_debp[p+1] && (m_run[p] < H);
            end
            m_sw = 0;
            case (m_phase)
                0: if (rise) begin
                    m_phase = 1;
                    m_act   = 0;
                end
                1: if (timeout_p1 === 1'b1 || timeout_p2 === 1'b1) begin
                    m_phase = 2;
                end else if (lng[0] || lng[1]) begin
                    m_phase = 2;
                    m_s1    = lng[0];
                    m_s2    = lng[1];
                end else if (shr[m_act]) begin
                    m_sw  = 1;
                    m_act = !m_act;
                end
                default: if (rise) begin
                    m_phase = 0;
                    m_s1    = 0;
                    m_s2    = 0;
                    m_act   = 0;
                end
            endcase
            for (int p = 0; p < 2; p++) begin
                if (!m_deb[p+1]) m_run[p] = 0;
                else if (m_run[p] <= H) m_run[p] = m_run[p] + 1;
            end
            for (int b = 0; b < 3; b++) begin
                flip = 1;
                for (int j = 1; j <= D; j++) begin
                    if (hist[b][j] == m_deb[b]) flip = 0;
                end
                m_debp[b] = m_deb[b];
                if (flip) m_deb[b] = !m_deb[b];
                for (int j = D; j >= 1; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = r[b];
            end
        end
        m_start = (m_phase == 1);
        m_go    = (m_phase == 2);
    endtask

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("start", start, m_start);
        chk("switch_turn", switch_turn, m_sw);
        chk("surrender_player1", surrender_player1, m_s1);
        chk("surrender_player2", surrender_player2, m_s2);
        chk("active_player", active_player, m_act);
        chk("game_over", game_over, m_go);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    endtask

    task automatic press_start();
        btn_start = 1;
        tick(10);
        btn_start = 0;
        tick(10);
    endtask

    initial begin
        reset      = 1;
        btn_start  = 0;
        btn_p1     = 0;
        btn_p2     = 0;
        timeout_p1 = 0;
        timeout_p2 = 0;
        tick(3);
        chk("lit_reset_start", start, 1'b0);
        chk("lit_reset_over", game_over, 1'b0);
        reset = 0;
        tick(1);

        // Start latency: 2 sync + 4 debounce + 1 registered.
        btn_start = 1;
        tick(6);
        chk("lit_start_early", start, 1'b0);
        tick(1);
        chk("lit_start_at7", start, 1'b1);
        chk("lit_start_act", active_player, 1'b0);
        tick(3);
        btn_start = 0;
        tick(10);

        // 8-cycle tap on player 1: pulse 7 cycles after the fall.
        btn_p1 = 1;
        tick(8);
        btn_p1 = 0;
        tick(6);
        chk("lit_sw_early", switch_turn, 1'b0);
        tick(1);
        chk("lit_sw_pulse", switch_turn, 1'b1);
        chk("lit_sw_act1", active_player, 1'b1);
        tick(1);
        chk("lit_sw_once", switch_turn, 1'b0);
        tick(10);
        btn_p1 = 1;
        tick(8);
        btn_p1 = 0;
        tick(15);
        chk("lit_p1_ignored", active_player, 1'b1);
        btn_p2 = 1;
        tick(8);
        btn_p2 = 0;
        tick(15);
        chk("lit_p2_act0", active_player, 1'b0);

        // Glitches and chatter never debounce.
        for (int w = 1; w <= 3; w++) begin
            btn_p1 = 1;
            tick(w);
            btn_p1 = 0;
            tick(10);
        end
        btn_p1 = 1;
        tick(3);
        btn_p1 = 0;
        tick(1);
        btn_p1 = 1;
        tick(3);
        btn_p1 = 0;
        tick(15);
        chk("lit_glitch_act", active_player, 1'b0);

        // Long press on player 2.
        btn_p2 = 1;
        tick(26);
        chk("lit_sur_early", game_over, 1'b0);
        tick(1);
        chk("lit_sur2", surrender_player2, 1'b1);
        chk("lit_sur_over", game_over, 1'b1);
        chk("lit_sur_start", start, 1'b0);
        chk("lit_sur1_clr", surrender_player1, 1'b0);
        tick(3);
        btn_p2 = 0;
        tick(15);
        chk("lit_sur_held", surrender_player2, 1'b1);
        btn_start = 1;
        tick(7);
        chk("lit_idle_over", game_over, 1'b0);
        chk("lit_idle_sur2", surrender_player2, 1'b0);
        tick(3);
        btn_start = 0;
        tick(10);

        // Timeout wins over a simultaneous long press.
        press_start();
        btn_p1 = 1;
        tick(26);
        timeout_p1 = 1;
        tick(1);
        timeout_p1 = 0;
        chk("lit_to_over", game_over, 1'b1);
        chk("lit_to_sur1", surrender_player1, 1'b0);
        chk("lit_to_sur2", surrender_player2, 1'b0);
        btn_p1 = 0;
        tick(10);
        press_start();
        press_start();
        btn_p1 = 1;
        btn_p2 = 1;
        tick(27);
        chk("lit_draw_sur1", surrender_player1, 1'b1);
        chk("lit_draw_sur2", surrender_player2, 1'b1);
        btn_p1 = 0;
        btn_p2 = 0;
        tick(10);
        press_start();

        // Reset mid-game with a paddle held.
        press_start();
        chk("lit_run_again", start, 1'b1);
        btn_p1 = 1;
        tick(10);
        reset = 1;
        tick(1);
        chk("lit_rst_start", start, 1'b0);
        chk("lit_rst_act", active_player, 1'b0);
        reset = 0;
        tick(3);
        btn_p1 = 0;
        tick(20);
        chk("lit_rst_nosw", switch_turn, 1'b0);

        // Random phase.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 14) == 0) btn_p1 = ~btn_p1;
            if ($urandom_range(0, 14) == 0) btn_p2 = ~btn_p2;
            timeout_p1 = ($urandom_range(0, 299) == 0);
            timeout_p2 = ($urandom_range(0, 299) == 0);
            reset      = ($urandom_range(0, 1499) == 0);
            tick(1);
        end
        reset      = 0;
        timeout_p1 = 0;
        timeout_p2 = 0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
